// File: rtl/gcd_stein.sv
// gcd_stein: binary (Stein) GCD coprocessor, one shift/subtract step per cycle.
// Optional CALC-cycle counter output enabled by GCD_CYCLE_COUNT_EN.
module gcd_stein #(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             START,
  output logic             BUSY,
  output logic [WIDTH-1:0] Y,
  output logic             DONE,
  output logic             ERROR
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [$clog2(2*WIDTH+2)-1:0] CYCLES
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [KW-1:0]    w_k_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic             w_err_nxt;
  logic [WIDTH-1:0] w_d_ab;
  logic [WIDTH-1:0] w_d_ba;
  logic             w_eq;
  logic             w_a_ev;
  logic             w_b_ev;
  logic             w_zero;
  logic             w_acc;

  assign w_eq   = (r_a == r_b);
  assign w_a_ev = ~r_a[0];
  assign w_b_ev = ~r_b[0];
  assign w_d_ab = r_a - r_b;
  assign w_d_ba = r_b - r_a;
  assign w_zero = (A == '0) || (B == '0);
  assign w_acc  = (r_state == S_IDLE) && START;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (START) w_state_nxt = w_zero ? S_FINISH : S_CALC;
      S_CALC:   if (w_eq) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: capture, Stein step, result
  always_comb begin
    w_a_nxt   = r_a;
    w_b_nxt   = r_b;
    w_k_nxt   = r_k;
    w_y_nxt   = Y;
    w_err_nxt = ERROR;
    unique case (r_state)
      S_IDLE: begin
        if (START) begin
          w_y_nxt   = '0;
          w_err_nxt = w_zero;
          if (!w_zero) begin
            w_a_nxt = A;
            w_b_nxt = B;
            w_k_nxt = '0;
          end
        end
      end
      S_CALC: begin
        if (w_eq) begin
          w_y_nxt = r_a << r_k;
        end else if (w_a_ev && w_b_ev) begin
          w_a_nxt = r_a >> 1;
          w_b_nxt = r_b >> 1;
          w_k_nxt = r_k + 1'b1;
        end else if (w_a_ev) begin
          w_a_nxt = r_a >> 1;
        end else if (w_b_ev) begin
          w_b_nxt = r_b >> 1;
        end else if (r_a > r_b) begin
          w_a_nxt = w_d_ab >> 1;
        end else begin
          w_b_nxt = w_d_ba >> 1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a   <= '0;
      r_b   <= '0;
      r_k   <= '0;
      Y     <= '0;
      ERROR <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_k   <= w_k_nxt;
      Y     <= w_y_nxt;
      ERROR <= w_err_nxt;
      BUSY  <= (w_state_nxt != S_IDLE);
      DONE  <= (w_state_nxt == S_FINISH);
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [$clog2(2*WIDTH+2)-1:0] r_cyc;

  // CALC cycle counter, cleared on accept, frozen outside CALC
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 r_cyc <= '0;
    else if (w_acc)             r_cyc <= '0;
    else if (r_state == S_CALC) r_cyc <= r_cyc + 1'b1;
  end

  assign CYCLES = r_cyc;
`else
  logic w_unused;
  assign w_unused = w_acc;
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: directed checks of gcd_stein at WIDTH=8 and WIDTH=16.
// Expected GCDs and latencies are hand-computed constants.
module tb_gcd_stein;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        st8 = 1'b0;
  logic        busy8, done8, err8;
  logic [7:0]  y8;
  logic [15:0] a16 = '0, b16 = '0;
  logic        st16 = 1'b0;
  logic        busy16, done16, err16;
  logic [15:0] y16;
`ifdef GCD_CYCLE_COUNT_EN
  logic [4:0]  cyc8;
  logic [5:0]  cyc16;
`endif

  int na = 0;
  int nf = 0;

  always #5 clk = ~clk;

  gcd_stein #(.WIDTH(8)) u8 (
    .CLK(clk), .RST_N(rst_n), .A(a8), .B(b8), .START(st8),
    .BUSY(busy8), .Y(y8), .DONE(done8), .ERROR(err8)
`ifdef GCD_CYCLE_COUNT_EN
    , .CYCLES(cyc8)
`endif
  );

  gcd_stein #(.WIDTH(16)) u16 (
    .CLK(clk), .RST_N(rst_n), .A(a16), .B(b16), .START(st16),
    .BUSY(busy16), .Y(y16), .DONE(done16), .ERROR(err16)
`ifdef GCD_CYCLE_COUNT_EN
    , .CYCLES(cyc16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    na++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic o_done(input bit w);
    return w ? done16 : done8;
  endfunction

  function automatic logic o_busy(input bit w);
    return w ? busy16 : busy8;
  endfunction

  function automatic logic o_err(input bit w);
    return w ? err16 : err8;
  endfunction

  function automatic logic [15:0] o_y(input bit w);
    return w ? y16 : {8'h00, y8};
  endfunction

  // Drive one accepted START; returns just after the accepting edge.
  task automatic go(input bit w, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    if (w) begin a16 = a; b16 = b; st16 = 1'b1; end
    else begin a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; end
    @(posedge clk); #1;
    st8 = 1'b0;
    st16 = 1'b0;
  endtask

  // Wait for DONE (edge count e includes the accepting edge) and check.
  task automatic fin(input bit w, input int e0, input logic [15:0] ey,
                     input logic eerr, input int exact, input int maxe);
    int e;
    e = e0;
    while (!o_done(w) && e < 80) begin
      @(posedge clk); #1;
      e++;
    end
    chk("done", o_done(w), 1'b1);
    chk("y", o_y(w), ey);
    chk("error", o_err(w), eerr);
    chk("busy_with_done", o_busy(w), 1'b1);
    if (exact != 0) chk("latency", e, exact);
    else chk("latency_bound", (e <= maxe), 1'b1);
    @(posedge clk); #1;
    chk("done_drop", o_done(w), 1'b0);
    chk("busy_drop", o_busy(w), 1'b0);
    chk("y_hold", o_y(w), ey);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_y", y8, 0);
    chk("rst_err", err8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    go(0, 48, 18);
    fin(0, 1, 6, 0, 0, 18);

    go(0, 200, 200);
    fin(0, 1, 200, 0, 2, 0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("cycles_eq", cyc8, 1);
`endif

    go(0, 0, 5);
    fin(0, 1, 0, 1, 1, 0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("cycles_err", cyc8, 0);
`endif
    go(0, 7, 0);
    fin(0, 1, 0, 1, 1, 0);
    go(0, 9, 6);
    fin(0, 1, 3, 0, 0, 18);

    go(0, 255, 1);
    fin(0, 1, 1, 0, 0, 18);
    go(0, 128, 64);
    fin(0, 1, 64, 0, 0, 18);

    go(1, 65535, 4369);
    fin(1, 1, 4369, 0, 0, 34);
    go(1, 65534, 32767);
    fin(1, 1, 32767, 0, 0, 34);

    // START with new operands while busy must be ignored
    go(0, 255, 1);
    @(negedge clk);
    a8 = 8'd4; b8 = 8'd2; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    fin(0, 2, 1, 0, 0, 18);

    // START held only during FINISH must not launch an operation
    go(0, 200, 200);
    @(posedge clk); #1;
    chk("finish_done", done8, 1'b1);
    a8 = 8'd9; b8 = 8'd6; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    chk("finish_start_ignored", busy8, 1'b0);
    @(posedge clk); #1;
    chk("finish_y_hold", y8, 200);

    // Asynchronous reset during CALC
    go(0, 255, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy8, 1'b0);
    chk("arst_done", done8, 1'b0);
    chk("arst_y", y8, 0);
    chk("arst_err", err8, 1'b0);
    @(posedge clk); #1;
    chk("arst_no_done", done8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    go(0, 48, 18);
    fin(0, 1, 6, 0, 0, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", na, nf);
    $finish;
  end

endmodule
